// File: rtl/pc_pkg.sv
// pc_pkg
//   Shared definitions for the fetch-stage program-counter unit.
//   - next_sel_e : which source the next PC is taken from
//   - DEFAULT_PC_WIDTH / DEFAULT_RESET_VECTOR : parameter defaults used by
//     pc_sequencer and pc_ras
package pc_pkg;

  localparam int          DEFAULT_PC_WIDTH     = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Next-PC source select, decoded once per cycle by the priority logic.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET
  } next_sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras
//   Circular return-address stack, RAS_DEPTH entries of PC_WIDTH bits.
//   A push onto a full stack overwrites the oldest entry.
//   A pop of an empty stack leaves the stack unchanged.
//   Ports:
//     clock, reset  rising-edge clock, synchronous active-high reset
//     push          write push_data as the new top entry
//     pop           discard the top entry (takes priority over push)
//     push_data     address to push
//     top           current top entry (meaningful only when !empty)
//     empty, full   occupancy flags
//     err_ovf       this cycle's push hits a full stack (combinational pulse)
//     err_unf       this cycle's pop hits an empty stack (combinational pulse)
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty,
  output logic                full,
  output logic                err_ovf,
  output logic                err_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    top_idx;
  logic                do_push;
  logic                do_pop;

  // wr_ptr points at the next free slot; the newest entry sits just below it.
  // Because RAS_DEPTH is a power of two, the pointer wraps for free, and when
  // the stack is full wr_ptr lands exactly on the oldest entry, so a push
  // overwrites it without any extra bookkeeping.
  assign top_idx = wr_ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));

  assign do_pop  = pop && !empty;
  assign do_push = push && !pop;
  assign err_unf = pop && empty;
  assign err_ovf = do_push && full;

  // Next-state for storage, pointer and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end else if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Only the pointer and count need resetting; stale entries are unreachable
  // once the count is zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter unit for the fetch stage. Holds the PC and picks the next
//   PC from sequential, branch, jump, call and return sources, with a fetch
//   stall and an internal return-address stack.
//   Ports:
//     clock, reset     rising-edge clock, synchronous active-high reset
//     stall            hold PC, ignore all redirects this cycle
//     branch_taken     redirect to branch_target
//     jump             redirect to jump_target
//     call             redirect to jump_target and push pc_out+PC_INCR
//     ret              pop the return-address stack into the PC
//     pc_out           registered current PC (instruction-memory address)
//     pc_next          combinational value pc_out takes at the next edge
//     pc_valid         pc_out is a fetchable address
//     ras_empty/full   return-address stack occupancy
//     ras_err          sticky overflow/underflow flag, cleared only by reset
//   Priority: reset > stall > ret > call > jump > branch_taken > sequential.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                  PC_INCR      = 1,
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic                call,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                pc_valid,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err
);

  localparam logic [PC_WIDTH-1:0] INCR = PC_WIDTH'(PC_INCR);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pc_valid_q, pc_valid_d;
  logic                ras_err_q, ras_err_d;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push;
  logic                ras_pop;
  logic                err_ovf;
  logic                err_unf;
  next_sel_e           sel;

  // Wraps modulo 2^PC_WIDTH through plain truncation.
  assign pc_seq = pc_q + INCR;

  pc_ras #(
    .PC_WIDTH (PC_WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_seq),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  // Priority decode of the redirect requests. The cycle right after reset
  // (pc_valid still low) holds the PC so RESET_VECTOR is fetched with
  // pc_valid high before the PC starts moving. A ret on an empty stack still
  // pops, so the stack reports the underflow, but the PC goes sequential.
  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!pc_valid_q || stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      ras_pop = 1'b1;
      sel     = ras_empty ? SEL_SEQ : SEL_RET;
    end else if (call) begin
      ras_push = 1'b1;
      sel      = SEL_JMP;
    end else if (jump) begin
      sel = SEL_JMP;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end
  end

  // Next-PC mux; reset overrides everything so pc_next matches what the
  // register will load.
  always_comb begin
    pc_d = pc_seq;
    if (reset) begin
      pc_d = RESET_VECTOR;
    end else begin
      unique case (sel)
        SEL_HOLD: pc_d = pc_q;
        SEL_SEQ:  pc_d = pc_seq;
        SEL_BR:   pc_d = branch_target;
        SEL_JMP:  pc_d = jump_target;
        SEL_RET:  pc_d = ras_top;
        default:  pc_d = pc_seq;
      endcase
    end
  end

  // The valid flag goes high on the first edge out of reset; the error flag
  // accumulates any overflow or underflow until the next reset.
  always_comb begin
    pc_valid_d = 1'b1;
    ras_err_d  = ras_err_q | err_ovf | err_unf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      ras_err_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ras_err_q  <= ras_err_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_next  = pc_d;
  assign pc_valid = pc_valid_q;
  assign ras_err  = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Drives a 32-bit and an 8-bit pc_sequencer with identical control inputs.
//   Because every PC operation is modular, the 8-bit unit must always equal
//   the low byte of the 32-bit one, so one queue-based reference model
//   predicts both.
module tb_pc_sequencer;

  localparam int RAS_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        call;
  logic [31:0] jump_target;
  logic        ret;

  logic [31:0] a_pc_out, a_pc_next;
  logic        a_pc_valid, a_ras_empty, a_ras_full, a_ras_err;
  logic [7:0]  b_pc_out, b_pc_next;
  logic        b_pc_valid, b_ras_empty, b_ras_full, b_ras_err;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state: architectural PC plus a queue of return addresses
  // (back of the queue is the newest entry).
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_ras [$];

  always #5 clock = ~clock;

  pc_sequencer #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(32'h0),
    .PC_INCR     (1),
    .RAS_DEPTH   (RAS_DEPTH)
  ) dut_a (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .call         (call),
    .jump_target  (jump_target),
    .ret          (ret),
    .pc_out       (a_pc_out),
    .pc_next      (a_pc_next),
    .pc_valid     (a_pc_valid),
    .ras_empty    (a_ras_empty),
    .ras_full     (a_ras_full),
    .ras_err      (a_ras_err)
  );

  pc_sequencer #(
    .PC_WIDTH    (8),
    .RESET_VECTOR(8'h0),
    .PC_INCR     (1),
    .RAS_DEPTH   (RAS_DEPTH)
  ) dut_b (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target[7:0]),
    .jump         (jump),
    .call         (call),
    .jump_target  (jump_target[7:0]),
    .ret          (ret),
    .pc_out       (b_pc_out),
    .pc_next      (b_pc_next),
    .pc_valid     (b_pc_valid),
    .ras_empty    (b_ras_empty),
    .ras_full     (b_ras_full),
    .ras_err      (b_ras_err)
  );

  // Address the PC should take at the coming edge, from the current inputs.
  function automatic logic [31:0] model_next();
    if (!m_valid || stall) return m_pc;
    if (ret) return (m_ras.size() > 0) ? m_ras[$] : m_pc + 32'd1;
    if (call || jump) return jump_target;
    if (branch_taken) return branch_target;
    return m_pc + 32'd1;
  endfunction

  // Advance the model by one clock edge.
  task automatic model_clock();
    if (reset) begin
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!stall) begin
      if (ret) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc  = m_pc + 32'd1;
          m_err = 1'b1;
        end
      end else if (call) begin
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
        m_ras.push_back(m_pc + 32'd1);
        m_pc = jump_target;
      end else if (jump) begin
        m_pc = jump_target;
      end else if (branch_taken) begin
        m_pc = branch_target;
      end else begin
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("pc_out_a",    a_pc_out,             m_pc);
    checkOutput("pc_out_b",    {24'h0, b_pc_out},    m_pc & 32'hFF);
    checkOutput("pc_valid_a",  {31'h0, a_pc_valid},  {31'h0, m_valid});
    checkOutput("pc_valid_b",  {31'h0, b_pc_valid},  {31'h0, m_valid});
    checkOutput("ras_empty_a", {31'h0, a_ras_empty}, {31'h0, m_ras.size() == 0});
    checkOutput("ras_empty_b", {31'h0, b_ras_empty}, {31'h0, m_ras.size() == 0});
    checkOutput("ras_full_a",  {31'h0, a_ras_full},  {31'h0, m_ras.size() == RAS_DEPTH});
    checkOutput("ras_full_b",  {31'h0, b_ras_full},  {31'h0, m_ras.size() == RAS_DEPTH});
    checkOutput("ras_err_a",   {31'h0, a_ras_err},   {31'h0, m_err});
    checkOutput("ras_err_b",   {31'h0, b_ras_err},   {31'h0, m_err});
  endtask

  // One clock cycle: drive inputs while the clock is low, check pc_next just
  // before the rising edge, then check registered state on the falling edge.
  task automatic applyStimulus(input bit rst, input bit st, input bit br,
                               input logic [31:0] bt, input bit jmp, input bit cl,
                               input logic [31:0] jt, input bit rt);
    logic [31:0] exp_next;
    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jmp;
    call          = cl;
    jump_target   = jt;
    ret           = rt;
    #1;
    if (!rst) begin
      exp_next = model_next();
      checkOutput("pc_next_a", a_pc_next, exp_next);
      checkOutput("pc_next_b", {24'h0, b_pc_next}, exp_next & 32'hFF);
    end
    @(posedge clock);
    model_clock();
    @(negedge clock);
    checkState();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] ret_expect [5];

  initial begin
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;

    // Reset for two cycles, then free-run: pc_out 0,0,0,1,2,3.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t1_reset_pc", a_pc_out, 32'h0);
    checkOutput("t1_reset_valid", {31'h0, a_pc_valid}, 32'h0);
    idle();
    checkOutput("t1_first_pc", a_pc_out, 32'h0);
    checkOutput("t1_first_valid", {31'h0, a_pc_valid}, 32'h1);
    idle();
    checkOutput("t1_pc1", a_pc_out, 32'h1);
    idle();
    idle();
    checkOutput("t1_pc3", a_pc_out, 32'h3);

    // Branch at pc=5.
    for (int i = 0; i < 20 && m_pc != 32'h5; i++) idle();
    checkOutput("t2_at5", a_pc_out, 32'h5);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t2_branch", a_pc_out, 32'h40);
    idle();
    checkOutput("t2_seq", a_pc_out, 32'h41);

    // Stall together with jump: PC frozen, then resumes at +1.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h999, 1'b0);
      checkOutput("t3_frozen", a_pc_out, 32'h41);
    end
    idle();
    checkOutput("t3_resume", a_pc_out, 32'h42);

    // Call to 0x100 from 0x10, three cycles, return to 0x11.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
    checkOutput("t4_call", a_pc_out, 32'h100);
    idle();
    idle();
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4_ret", a_pc_out, 32'h11);
    checkOutput("t4_empty", {31'h0, a_ras_empty}, 32'h1);

    // Five nested calls on a four-deep stack, then five returns.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200 + 32'h100 * i, 1'b0);
    end
    checkOutput("t5_full", {31'h0, a_ras_full}, 32'h1);
    checkOutput("t5_ovf_err", {31'h0, a_ras_err}, 32'h1);
    ret_expect[0] = 32'h501;
    ret_expect[1] = 32'h401;
    ret_expect[2] = 32'h301;
    ret_expect[3] = 32'h201;
    ret_expect[4] = 32'h202;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t5_ret", a_pc_out, ret_expect[i]);
    end
    checkOutput("t5_err", {31'h0, a_ras_err}, 32'h1);

    // Wrap of the 8-bit unit, then call+ret on an empty stack.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_err_cleared", {31'h0, a_ras_err}, 32'h0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFF, 1'b0);
    checkOutput("t6_at_ff", {24'h0, b_pc_out}, 32'hFF);
    idle();
    checkOutput("t6_wrap8", {24'h0, b_pc_out}, 32'h00);
    checkOutput("t6_nowrap32", a_pc_out, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55, 1'b1);
    checkOutput("t6_callret_pc", {24'h0, b_pc_out}, 32'h01);
    checkOutput("t6_callret_err", {31'h0, b_ras_err}, 32'h1);
    checkOutput("t6_callret_empty", {31'h0, b_ras_empty}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_reset_err", {31'h0, b_ras_err}, 32'h0);
    idle();

    // 32-bit wrap at the maximum address.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    idle();
    checkOutput("wrap32", a_pc_out, 32'h0);

    // Random mix of all requests, checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(63) == 0,
                    $urandom_range(4) == 0,
                    $urandom_range(3) == 0,
                    $urandom,
                    $urandom_range(5) == 0,
                    $urandom_range(4) == 0,
                    $urandom,
                    $urandom_range(4) == 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
